// File: rtl/lcd_line_fifo.sv
// lcd_line_fifo: parametrised single-clock FIFO that buffers LCD pixel/line
// data between the pixel generator and the timing controller. Storage is an
// inferred RAM. Occupancy and all status flags are registered. The read side
// works in either normal mode (q valid one cycle after rdreq) or show-ahead
// mode (q presents the head word while not empty).
module lcd_line_fifo #(
  parameter int unsigned DW       = 20,
  parameter int unsigned AW       = 9,
  parameter int unsigned AF_LEVEL = 2**AW - 4,
  parameter int unsigned AE_LEVEL = 4,
  parameter int unsigned FWFT     = 0
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          sclr,
  input  logic [DW-1:0] data,
  input  logic          wrreq,
  input  logic          rdreq,
  output logic [DW-1:0] q,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic [AW:0]   usedw,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_accept;
  logic          wr_accept;
  logic          ram_we;
  logic          ram_re;
  logic          load_bypass;
  logic [AW:0]   ram_count;
  logic [AW:0]   usedw_next;

  // Accept decisions, RAM port control and next occupancy.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    rd_accept   = rdreq && !empty;
    wr_accept   = wrreq && (!full || rd_accept);
    ram_count   = usedw - (AW+1)'(!empty);
    ram_we      = wr_accept;
    ram_re      = rd_accept;
    load_bypass = 1'b0;
    if (FWFT != 0) begin
      // In show-ahead mode the output register holds the head word and is
      // counted in usedw; it is refilled whenever it is vacant or being
      // popped, from the RAM if the RAM holds words, else straight from data.
      ram_re = 1'b0;
      if (rd_accept || empty) begin
        if (ram_count != '0) begin
          ram_re = 1'b1;
        end else if (wr_accept) begin
          load_bypass = 1'b1;
          ram_we      = 1'b0;
        end
      end
    end
    if (sclr) begin
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      load_bypass = 1'b0;
    end
    usedw_next = usedw + (AW+1)'(wr_accept) - (AW+1)'(rd_accept);
  end

  // RAM write port.
  // NOTE: the array has no reset so it maps onto block RAM; pointers and usedw say what is valid.
  // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr] <= data;
  end

  // Pointers, output word, occupancy, registered flags and sticky errors.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      q            <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (sclr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      q            <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + AW'(1);
      if (ram_re) begin
        rd_ptr <= rd_ptr + AW'(1);
        q      <= mem[rd_ptr];
      end else if (load_bypass) begin
        q <= data;
      end
      usedw        <= usedw_next;
      empty        <= (usedw_next == '0);
      full         <= (usedw_next == DEPTH_W);
      almost_empty <= (32'(usedw_next) <= AE_LEVEL);
      almost_full  <= (32'(usedw_next) >= AF_LEVEL);
      overflow     <= overflow  | (wrreq && !wr_accept);
      underflow    <= underflow | (rdreq && empty);
    end
  end

endmodule

// File: tb/tb_lcd_line_fifo.sv
// tb_lcd_line_fifo: drives one normal-mode and one show-ahead instance with
// the same stimulus and checks both against a queue-based reference model.
module tb_lcd_line_fifo;

  localparam int DW    = 20;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          aclr;
  logic          sclr;
  logic          wrreq;
  logic          rdreq;
  logic [DW-1:0] data;

  logic [DW-1:0] n_q, f_q;
  logic          n_empty, f_empty, n_full, f_full;
  logic          n_ae, f_ae, n_af, f_af;
  logic [AW:0]   n_usedw, f_usedw;
  logic          n_ovf, f_ovf, n_udf, f_udf;

  lcd_line_fifo #(.DW(DW), .AW(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_norm (
    .clk(clk), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(n_q), .empty(n_empty), .full(n_full), .almost_empty(n_ae), .almost_full(n_af),
    .usedw(n_usedw), .overflow(n_ovf), .underflow(n_udf)
  );

  lcd_line_fifo #(.DW(DW), .AW(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(f_q), .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .usedw(f_usedw), .overflow(f_ovf), .underflow(f_udf)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_bad = 0;
  string         phase = "init";

  // Reference model state.
  logic [DW-1:0] sb [$];
  int            cnt;
  bit            ovf;
  bit            udf;
  logic [DW-1:0] last_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    cnt    = 0;
    ovf    = 1'b0;
    udf    = 1'b0;
    last_q = '0;
  endtask

  // Compare both instances against the model.
  task automatic check_state();
    check("n_usedw", 64'(n_usedw), 64'(cnt));
    check("f_usedw", 64'(f_usedw), 64'(cnt));
    check("n_empty", 64'(n_empty), 64'(cnt == 0));
    check("f_empty", 64'(f_empty), 64'(cnt == 0));
    check("n_full",  64'(n_full),  64'(cnt == DEPTH));
    check("f_full",  64'(f_full),  64'(cnt == DEPTH));
    check("n_ae",    64'(n_ae),    64'(cnt <= AE));
    check("f_ae",    64'(f_ae),    64'(cnt <= AE));
    check("n_af",    64'(n_af),    64'(cnt >= AF));
    check("f_af",    64'(f_af),    64'(cnt >= AF));
    check("n_ovf",   64'(n_ovf),   64'(ovf));
    check("f_ovf",   64'(f_ovf),   64'(ovf));
    check("n_udf",   64'(n_udf),   64'(udf));
    check("f_udf",   64'(f_udf),   64'(udf));
    check("n_q",     64'(n_q),     64'(last_q));
    if (cnt != 0) check("f_q", 64'(f_q), 64'(sb[0]));
  endtask

  task automatic check_reset();
    check_state();
    check("f_q_rst", 64'(f_q), 64'(0));
  endtask

  // One clock of stimulus: update the model from pre-edge state, then sample #1 after the edge.
  task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rd, input bit sc);
    bit rd_ok;
    bit wr_ok;
    wrreq = wr;
    data  = d;
    rdreq = rd;
    sclr  = sc;
    if (sc) begin
      model_reset();
    end else begin
      rd_ok = rd && (cnt != 0);
      wr_ok = wr && ((cnt != DEPTH) || rd_ok);
      if (rd && !rd_ok) udf = 1'b1;
      if (wr && !wr_ok) ovf = 1'b1;
      if (rd_ok) last_q = sb.pop_front();
      if (wr_ok) sb.push_back(d);
      cnt = cnt + int'(wr_ok) - int'(rd_ok);
    end
    @(posedge clk);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr  = 1'b0;
    check_state();
  endtask

  initial begin
    aclr  = 1'b1;
    sclr  = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = '0;
    model_reset();

    // Reset then fill past full.
    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    #2 aclr = 1'b0;
    phase = "fill";
    for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    phase = "overflow";
    cycle(1'b1, DW'('h11), 1'b0, 1'b0);

    // Drain in normal mode, then read once more while empty.
    phase = "drain";
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    phase = "underflow";
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Show-ahead: a word written into an empty FIFO appears on q at once.
    phase = "showahead";
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, DW'('hABCDE), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous access while full, across pointer wrap.
    phase = "simul_full";
    for (int i = 0; i < 16; i++) cycle(1'b1, DW'('h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'('h200 + i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    phase = "simul_empty";
    cycle(1'b1, DW'('h30303), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush with a concurrent write; the write must be discarded.
    phase = "flush";
    for (int i = 0; i < 9; i++) cycle(1'b1, DW'('h400 + i), 1'b0, 1'b0);
    cycle(1'b1, DW'('hDEAD0), 1'b0, 1'b1);
    cycle(1'b1, DW'('h55555), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a read burst.
    phase = "aclr_mid";
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'('h600 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    rdreq = 1'b1;
    #2;
    aclr  = 1'b1;
    rdreq = 1'b0;
    #1;
    model_reset();
    check_reset();
    @(posedge clk);
    #3 aclr = 1'b0;
    phase = "after_aclr";
    cycle(1'b1, DW'('h77777), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_line_fifo.md
Name: lcd_line_fifo

Overview:
Parametrised single-clock FIFO for buffering LCD pixel and line data between the pixel generator and the timing controller. It is the successor to the fixed 20-bit vendor-FIFO wrapper, and adds:
- configurable width and depth
- programmable almost-full and almost-empty thresholds
- an occupancy count
- selectable show-ahead (FWFT) or normal read mode
- synchronous flush
- sticky overflow and underflow error flags

Storage is an inferred RAM, so no vendor macro is needed and the same RTL works on every board variant.

Parameters:
DW, 20, data width in bits (1..64).
AW, 9, address width; depth = 2**AW words.
AF_LEVEL, 2**AW-4, almost_full asserts when usedw >= AF_LEVEL.
AE_LEVEL, 4, almost_empty asserts when usedw <= AE_LEVEL.
FWFT, 0, 0 = normal read (q valid 1 cycle after rdreq); 1 = show-ahead (q shows head word while !empty).

Ports:
clk  in  1  single clock; all logic on rising edge.
aclr  in  1  asynchronous active-high reset.
sclr  in  1  synchronous flush, active-high.
data  in  DW  write data.
wrreq  in  1  write request.
rdreq  in  1  read request.
q  out  DW  read data.
empty  out  1  no words available.
full  out  1  2**AW words stored.
almost_empty  out  1  usedw <= AE_LEVEL.
almost_full  out  1  usedw >= AF_LEVEL.
usedw  out  AW+1  occupancy, 0..2**AW.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, aclr.
- Reset (aclr=1, or sclr=1 at an edge):
  - pointers, usedw, q, overflow, underflow -> 0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - RAM contents don't-care
  - aclr mid-operation: all in-flight data discarded immediately; the first edge after release behaves as an empty FIFO.
  - sclr has priority over wrreq and rdreq in the same cycle.
- Write accepted when wrreq && (!full || rd_accept): data stored at wr_ptr, wr_ptr increments modulo 2**AW.
- Read accepted (rd_accept) when rdreq && !empty.
- Full with simultaneous wrreq and rdreq: both accepted, usedw unchanged, full stays 1.
- Empty with simultaneous wrreq and rdreq: read rejected, underflow set, write accepted, usedw -> 1.
- Rejected write when full and no read: data dropped, overflow set.
- Rejected read when empty: underflow set. q unchanged in normal mode.
- Sticky flags clear only on aclr or sclr.
- Occupancy: usedw += wr_accept - rd_accept each edge. All flags are registered, derived from the next usedw value, and change on the same edge as usedw.
- Normal mode (FWFT=0):
  - on a read-accept edge, q loads the head word, so it is valid in the cycle after rdreq.
  - q otherwise holds its last value.
- Show-ahead mode (FWFT=1):
  - q always presents the head word while empty=0; rdreq acts as a pop acknowledge.
  - a word written into an empty FIFO appears on q, with empty=0, after the same edge that accepts the write. This needs a bypass/prefetch register so there is no extra latency.
  - usedw counts the word held in the output register.
- Pointer wrap: pointers are AW bits; full/empty are derived from usedw, never from pointer compare alone.
- Thresholds: AF_LEVEL and AE_LEVEL are not range-checked. AF_LEVEL > 2**AW means almost_full never asserts.

Test Plan:
1. Reset and fill, DW=20, AW=4, FWFT=0: assert aclr, then write 16 words 0x00001..0x00010.
   - after reset: empty=1, usedw=0.
   - after the 12th write: almost_full=1.
   - after the 16th: full=1, usedw=16.
   - a 17th write: overflow=1, usedw stays 16.
2. Drain in normal mode: rdreq 16 cycles. q = 0x00001..0x00010, each one cycle after its rdreq. almost_empty asserts at usedw=4, empty=1 at the end. A 17th rdreq sets underflow=1 and q holds 0x00010.
3. Show-ahead: FWFT=1, write 0xABCDE into an empty FIFO. Next cycle: q=0xABCDE, empty=0, usedw=1. Then rdreq: empty=1, usedw=0.
4. Simultaneous access:
   - full FIFO with wrreq+rdreq for 20 cycles: usedw stays 16 and data order is preserved across pointer wrap.
   - empty FIFO with wrreq+rdreq: underflow=1, usedw=1.
5. Flush: with 9 words stored, pulse sclr together with wrreq. Next cycle: usedw=0, empty=1, overflow=0, underflow=0, and the write is discarded.
6. Async reset mid-burst: assert aclr between edges during a read burst. Outputs go to reset values before the next edge; after release, a new write/read returns the new data only.
